// File: rtl/reg_writeback_ctrl_if.sv
// Write-back handshake bus: one retiring result per accepted transfer,
// carrying the source select, destinations and all candidate data words.
interface reg_writeback_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  logic              wb_valid;
  logic              wb_ready;
  logic [1:0]        wb_src;
  logic [REG_AW-1:0] wb_dest;
  logic              wb_byte;
  logic              wb_sext;
  logic              wb_upd;
  logic [REG_AW-1:0] wb_upd_reg;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] pc_next;
  logic [DATA_W-1:0] upd_data;

  // Producer side (multicycle datapath)
  modport master (
    output wb_valid, wb_src, wb_dest, wb_byte, wb_sext, wb_upd, wb_upd_reg,
           alu_result, mem_data, pc_next, upd_data,
    input  wb_ready
  );

  // Consumer side (write-back controller)
  modport slave (
    input  wb_valid, wb_src, wb_dest, wb_byte, wb_sext, wb_upd, wb_upd_reg,
           alu_result, mem_data, pc_next, upd_data,
    output wb_ready
  );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// Write-back controller for the 8x16 register file write port.
// Accepts one result per handshake, drives a registered RegWrite/WriteReg/
// WriteData, optionally follows with a second (post-increment) write, and
// exposes the pending destination for RAW-hazard stalling in decode.
module reg_writeback_ctrl #(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 3,
  parameter int LINK_REG = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_writeback_ctrl_if.slave wb,
  output logic              RegWrite,
  output logic [REG_AW-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              pend_valid,
  output logic [REG_AW-1:0] pend_reg,
  output logic [15:0]       wr_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR1  = 2'd1;
  localparam logic [1:0] ST_WR2  = 2'd2;

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_MEM  = 2'b01;
  localparam logic [1:0] SRC_LINK = 2'b10;

  localparam logic [REG_AW-1:0] LINK_ADDR = REG_AW'(LINK_REG);
  localparam logic [REG_AW-1:0] R0_ADDR   = '0;

  // Byte-load extension: sign- or zero-extend the low byte of memory data.
  function automatic logic [DATA_W-1:0] byte_ext(input logic [DATA_W-1:0] d,
                                                 input logic              sext);
    logic signed [7:0] b;
    b = signed'(d[7:0]);
    if (sext) return DATA_W'(b);
    return DATA_W'(d[7:0]);
  endfunction

  // Result mux; the reserved source code falls back to the ALU result.
  function automatic logic [DATA_W-1:0] sel_data(input logic [1:0]        src,
                                                 input logic              byte_ld,
                                                 input logic              sext,
                                                 input logic [DATA_W-1:0] alu,
                                                 input logic [DATA_W-1:0] mem,
                                                 input logic [DATA_W-1:0] pc);
    case (src)
      SRC_MEM:  return byte_ld ? byte_ext(mem, sext) : mem;
      SRC_LINK: return pc;
      default:  return alu;
    endcase
  endfunction

  logic [1:0]        state_q,      state_d;
  logic              regwrite_q,   regwrite_d;
  logic [REG_AW-1:0] write_reg_q,  write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              pend_valid_q, pend_valid_d;
  logic [REG_AW-1:0] pend_reg_q,   pend_reg_d;
  logic [15:0]       wr_count_q,   wr_count_d;
  logic              upd_q,        upd_d;
  logic [REG_AW-1:0] upd_reg_q,    upd_reg_d;
  logic [DATA_W-1:0] upd_data_q,   upd_data_d;

  logic              ready;
  logic              accept;
  logic [REG_AW-1:0] prim_dest;

  // Ready is blocked only while a primary write still owes its second write.
  always_comb begin
    ready     = (state_q == ST_IDLE) || (state_q == ST_WR2) ||
                ((state_q == ST_WR1) && !upd_q);
    accept    = wb.wb_valid && ready;
    prim_dest = (wb.wb_src == SRC_LINK) ? LINK_ADDR : wb.wb_dest;
  end

  assign wb.wb_ready = ready;

  // Next-state and next-output logic for the write sequencer.
  always_comb begin
    state_d      = ST_IDLE;
    regwrite_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    pend_valid_d = 1'b0;
    pend_reg_d   = pend_reg_q;
    upd_d        = 1'b0;
    upd_reg_d    = upd_reg_q;
    upd_data_d   = upd_data_q;

    if (accept) begin
      state_d      = ST_WR1;
      write_reg_d  = prim_dest;
      write_data_d = sel_data(wb.wb_src, wb.wb_byte, wb.wb_sext,
                              wb.alu_result, wb.mem_data, wb.pc_next);
      regwrite_d   = (prim_dest != R0_ADDR);
      pend_valid_d = 1'b1;
      pend_reg_d   = prim_dest;
      upd_d        = wb.wb_upd;
      upd_reg_d    = wb.wb_upd_reg;
      upd_data_d   = wb.upd_data;
    end else if ((state_q == ST_WR1) && upd_q) begin
      state_d      = ST_WR2;
      write_reg_d  = upd_reg_q;
      write_data_d = upd_data_q;
      regwrite_d   = (upd_reg_q != R0_ADDR);
      pend_valid_d = 1'b1;
      pend_reg_d   = upd_reg_q;
    end

    // Count tracks the registered strobe so it is current in the write cycle.
    wr_count_d = wr_count_q + {15'd0, regwrite_d};
  end

  // Control and visible write-port state, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      pend_valid_q <= 1'b0;
      pend_reg_q   <= '0;
      wr_count_q   <= '0;
      upd_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      pend_valid_q <= pend_valid_d;
      pend_reg_q   <= pend_reg_d;
      wr_count_q   <= wr_count_d;
      upd_q        <= upd_d;
    end
  end

  // Second-write payload; only meaningful while upd_q is set, so no reset.
  always_ff @(posedge clk) begin
    upd_reg_q  <= upd_reg_d;
    upd_data_q <= upd_data_d;
  end

  assign RegWrite   = regwrite_q;
  assign WriteReg   = write_reg_q;
  assign WriteData  = write_data_q;
  assign pend_valid = pend_valid_q;
  assign pend_reg   = pend_reg_q;
  assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed bench for reg_writeback_ctrl: reset, source select, byte
// extension, CALL link write, post-increment, R0 rule, reset during the
// second write, and wr_count wrap.
module tb_reg_writeback_ctrl;

  logic        clk;
  logic        rst_n;
  logic        RegWrite;
  logic [2:0]  WriteReg;
  logic [15:0] WriteData;
  logic        pend_valid;
  logic [2:0]  pend_reg;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;

  reg_writeback_ctrl_if #(.DATA_W(16), .REG_AW(3)) bus ();

  reg_writeback_ctrl #(.DATA_W(16), .REG_AW(3), .LINK_REG(7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb         (bus),
    .RegWrite   (RegWrite),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .pend_valid (pend_valid),
    .pend_reg   (pend_reg),
    .wr_count   (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] src, input logic [2:0] dest,
                       input logic byt, input logic sx, input logic upd,
                       input logic [2:0] ureg, input logic [15:0] alu,
                       input logic [15:0] mem, input logic [15:0] pc,
                       input logic [15:0] udata);
    bus.wb_valid   = v;
    bus.wb_src     = src;
    bus.wb_dest    = dest;
    bus.wb_byte    = byt;
    bus.wb_sext    = sx;
    bus.wb_upd     = upd;
    bus.wb_upd_reg = ureg;
    bus.alu_result = alu;
    bus.mem_data   = mem;
    bus.pc_next    = pc;
    bus.upd_data   = udata;
  endtask

  task automatic idle_bus();
    drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask

  // Advance one clock and settle 1 ns past the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_bus();
    #12;
    chk("rst_regwrite",  {31'd0, RegWrite},   32'd0);
    chk("rst_writereg",  {29'd0, WriteReg},   32'd0);
    chk("rst_writedata", {16'd0, WriteData},  32'd0);
    chk("rst_pend_valid",{31'd0, pend_valid}, 32'd0);
    chk("rst_pend_reg",  {29'd0, pend_reg},   32'd0);
    chk("rst_wr_count",  {16'd0, wr_count},   32'd0);
    chk("rst_ready",     {31'd0, bus.wb_ready}, 32'd1);
    rst_n = 1'b1;

    // ALU source, dest 3
    drive(1'b1, 2'b00, 3'd3, 1'b0, 1'b0, 1'b0, 3'd0, 16'h1234, 16'h0, 16'h0, 16'h0);
    step();
    idle_bus();
    chk("alu_regwrite",  {31'd0, RegWrite},  32'd1);
    chk("alu_writereg",  {29'd0, WriteReg},  32'd3);
    chk("alu_writedata", {16'd0, WriteData}, 32'h1234);
    chk("alu_wr_count",  {16'd0, wr_count},  32'd1);
    chk("alu_pend",      {28'd0, pend_valid, pend_reg}, 32'hB);
    step();
    chk("idle_regwrite", {31'd0, RegWrite},  32'd0);
    chk("idle_hold_data",{16'd0, WriteData}, 32'h1234);
    chk("idle_pend_valid",{31'd0, pend_valid}, 32'd0);

    // Byte loads back-to-back: sign-extend then zero-extend
    drive(1'b1, 2'b01, 3'd2, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0, 16'h0080, 16'h0, 16'h0);
    chk("byte_ready0", {31'd0, bus.wb_ready}, 32'd1);
    step();
    chk("sext_data",   {16'd0, WriteData}, 32'hFF80);
    chk("sext_reg",    {29'd0, WriteReg},  32'd2);
    chk("byte_ready1", {31'd0, bus.wb_ready}, 32'd1);
    drive(1'b1, 2'b01, 3'd2, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0080, 16'h0, 16'h0);
    step();
    idle_bus();
    chk("zext_data",   {16'd0, WriteData}, 32'h0080);
    chk("zext_we",     {31'd0, RegWrite},  32'd1);
    chk("byte_ready2", {31'd0, bus.wb_ready}, 32'd1);
    chk("byte_count",  {16'd0, wr_count},  32'd3);

    // CALL link write: dest ignored, R7 gets pc_next
    drive(1'b1, 2'b10, 3'd5, 1'b0, 1'b0, 1'b0, 3'd0, 16'hAAAA, 16'h0, 16'h0041, 16'h0);
    step();
    idle_bus();
    chk("call_we",    {31'd0, RegWrite},  32'd1);
    chk("call_reg",   {29'd0, WriteReg},  32'd7);
    chk("call_data",  {16'd0, WriteData}, 32'h0041);
    chk("call_pend",  {29'd0, pend_reg},  32'd7);
    chk("call_count", {16'd0, wr_count},  32'd4);
    step();

    // Load post-increment: R1 <= mem, then R4 <= upd_data
    drive(1'b1, 2'b01, 3'd1, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0, 16'hBEEF, 16'h0, 16'h0102);
    step();
    idle_bus();
    chk("pi1_we",    {31'd0, RegWrite},  32'd1);
    chk("pi1_reg",   {29'd0, WriteReg},  32'd1);
    chk("pi1_data",  {16'd0, WriteData}, 32'hBEEF);
    chk("pi1_ready", {31'd0, bus.wb_ready}, 32'd0);
    chk("pi1_pend",  {28'd0, pend_valid, pend_reg}, 32'h9);
    step();
    chk("pi2_we",    {31'd0, RegWrite},  32'd1);
    chk("pi2_reg",   {29'd0, WriteReg},  32'd4);
    chk("pi2_data",  {16'd0, WriteData}, 32'h0102);
    chk("pi2_ready", {31'd0, bus.wb_ready}, 32'd1);
    chk("pi2_pend",  {28'd0, pend_valid, pend_reg}, 32'hC);
    chk("pi2_count", {16'd0, wr_count},  32'd6);
    step();
    chk("pi_idle_we",   {31'd0, RegWrite},   32'd0);
    chk("pi_idle_pend", {31'd0, pend_valid}, 32'd0);

    // R0 destination: output cycle used, no strobe, count unchanged
    drive(1'b1, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 16'hFFFF, 16'h0, 16'h0, 16'h0);
    step();
    idle_bus();
    chk("r0_we",    {31'd0, RegWrite},  32'd0);
    chk("r0_data",  {16'd0, WriteData}, 32'hFFFF);
    chk("r0_reg",   {29'd0, WriteReg},  32'd0);
    chk("r0_pend",  {31'd0, pend_valid}, 32'd1);
    chk("r0_count", {16'd0, wr_count},  32'd6);
    step();

    // Reserved source behaves as ALU; collision R5/R5 issues both in order
    drive(1'b1, 2'b11, 3'd5, 1'b0, 1'b0, 1'b1, 3'd5, 16'h5A5A, 16'h1111, 16'h2222, 16'hC3C3);
    step();
    idle_bus();
    chk("rsv_data",  {16'd0, WriteData}, 32'h5A5A);
    chk("col1_reg",  {29'd0, WriteReg},  32'd5);
    step();
    chk("col2_we",   {31'd0, RegWrite},  32'd1);
    chk("col2_data", {16'd0, WriteData}, 32'hC3C3);
    chk("col_count", {16'd0, wr_count},  32'd8);
    step();

    // Reset asserted during the second write
    drive(1'b1, 2'b00, 3'd3, 1'b0, 1'b0, 1'b1, 3'd6, 16'h7777, 16'h0, 16'h0, 16'h6666);
    step();
    idle_bus();
    step();
    chk("mid_wr2_we", {31'd0, RegWrite}, 32'd1);
    chk("mid_wr2_reg",{29'd0, WriteReg}, 32'd6);
    rst_n = 1'b0;
    #1;
    chk("arst_we",    {31'd0, RegWrite},   32'd0);
    chk("arst_count", {16'd0, wr_count},   32'd0);
    chk("arst_pend",  {31'd0, pend_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_we1", {31'd0, RegWrite}, 32'd0);
    step();
    chk("post_rst_we2",   {31'd0, RegWrite},  32'd0);
    chk("post_rst_count", {16'd0, wr_count},  32'd0);
    chk("post_rst_data",  {16'd0, WriteData}, 32'd0);

    // Back-to-back writes to bring wr_count to 0xFFFF, then wrap
    drive(1'b1, 2'b00, 3'd1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0001, 16'h0, 16'h0, 16'h0);
    repeat (65535) @(posedge clk);
    #1;
    chk("cnt_ffff",   {16'd0, wr_count}, 32'hFFFF);
    chk("cnt_ready",  {31'd0, bus.wb_ready}, 32'd1);
    step();
    idle_bus();
    chk("cnt_wrap",   {16'd0, wr_count}, 32'h0000);
    chk("cnt_wrap_we",{31'd0, RegWrite}, 32'd1);
    step();
    chk("cnt_hold",   {16'd0, wr_count}, 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
